// File: rtl/sm_hex_display_scan_pkg.sv
// Shared display definitions: active-high hex segment map and off-level helpers
// used by the scan driver and its decoder.
package sm_display_pkg;

    // Segment order per entry is {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_MAP = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_off(input bit active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

    function automatic logic dig_off(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/sm_hex_display_scan_if.sv
// Scan-driver signal bundle: live data/controls in, registered display drive out.
interface sm_hex_display_scan_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  lzBlank;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dpMask;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     dig;
    logic                  frameDone;

    modport master (
        output enable, lzBlank, data, dpMask,
        input  seg, dp, dig, frameDone
    );

    modport slave (
        input  enable, lzBlank, data, dpMask,
        output seg, dp, dig, frameDone
    );
endinterface

// File: rtl/sm_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module sm_hex_to_seg
    import sm_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_MAP[nibble_i];

endmodule

// File: rtl/sm_hex_display_scan.sv
// Multiplexed hex display scanner: per-frame data snapshot, ghost-guard blanking per
// digit slot, optional leading-zero blanking, fully registered outputs.
module sm_hex_display_scan
    import sm_display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 25000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    sm_hex_display_scan_if.slave  bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF   = seg_off(SEG_ACTIVE_LOW);
    localparam logic              DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF   = {DIGITS{dig_off(DIG_ACTIVE_LOW)}};

    if (SCAN_DIV < BLANK_CYCLES + 2 || DIGITS < 1) begin : g_bad_params
        $error("sm_hex_display_scan: need SCAN_DIV >= BLANK_CYCLES+2 and DIGITS >= 1");
    end

    logic [CNT_W-1:0]          cnt_q,  cnt_d;
    logic [IDX_W-1:0]          idx_q,  idx_d;
    logic [DIGITS-1:0][3:0]    snap_q, snap_d;
    logic                      frame_done_q, frame_done_d;
    logic [6:0]                seg_q,  seg_d;
    logic                      dp_q,   dp_d;
    logic [DIGITS-1:0]         dig_q,  dig_d;

    logic [6:0]                seg_raw;
    logic [DIGITS-1:0]         lz_off;

    sm_hex_to_seg u_hex_to_seg (
        .nibble_i (snap_q[idx_q]),
        .seg_o    (seg_raw)
    );

    // Digit i>0 is blank when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_off     = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (snap_q[i] == 4'h0);
            lz_off[i]  = bus.lzBlank & zero_above;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
        seg_d        = seg_raw ^ SEG_OFF;
        dp_d         = bus.dpMask[idx_q] ^ DP_OFF;
        dig_d        = DIG_OFF;

        if (bus.enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d        = '0;
                    snap_d       = bus.data;
                    frame_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (cnt_q >= CNT_BLANK && !lz_off[idx_q]) begin
                dig_d = (DIGITS'(1) << idx_q) ^ DIG_OFF;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            dig_q        <= DIG_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.dig       = dig_q;
    assign bus.frameDone = frame_done_q;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Directed bench for sm_hex_display_scan with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low drive.
module tb_sm_hex_display_scan;

    logic clk;
    logic rst;

    sm_hex_display_scan_if #(.DIGITS(4)) bus ();

    sm_hex_display_scan #(
        .DIGITS         (4),
        .SCAN_DIV       (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] data;
        logic        lz;
        logic [3:0]  dpm;
        int          slot;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        dp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic lz, input logic [3:0] dpm);
        bus.data    = d;
        bus.lzBlank = lz;
        bus.dpMask  = dpm;
    endtask

    initial begin
        rst         = 1'b1;
        bus.enable  = 1'b1;
        set_inputs(16'h12AF, 1'b0, 4'h0);

        // Reset held for 3 cycles with enable high: outputs stay at off levels.
        tick(3);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_dig", 32'(bus.dig), 32'hF);
        check("rst_frame_done", 32'(bus.frameDone), 32'h0);
        rst = 1'b0;
        tick(1);
        check("post_rst_guard_c1", 32'(bus.dig), 32'hF);
        tick(1);
        check("post_rst_guard_c2", 32'(bus.dig), 32'hF);
        tick(1);
        check("post_rst_dig0_on", 32'(bus.dig), 32'hE);
        check("post_rst_seg_zero", 32'(bus.seg), 32'h40);

        // frameDone: exactly one pulse, on edge 32 after reset release.
        begin
            int fd_edge;
            int fd_count;
            do_reset();
            set_inputs(16'h12AF, 1'b0, 4'h0);
            fd_edge  = -1;
            fd_count = 0;
            for (int e = 1; e <= 40; e++) begin
                tick(1);
                if (bus.frameDone) begin
                    fd_count++;
                    if (fd_edge < 0) fd_edge = e;
                end
            end
            check("frame_done_edge", 32'(fd_edge), 32'd32);
            check("frame_done_count", 32'(fd_count), 32'd1);
        end

        // Table: load a frame, then inspect the given slot at cnt=2 of that slot.
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 0, 7'h0E, 4'b1110, 1'b1});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 1, 7'h08, 4'b1101, 1'b1});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 2, 7'h24, 4'b1011, 1'b1});
        vecs.push_back('{16'h12AF, 1'b0, 4'b0000, 3, 7'h79, 4'b0111, 1'b1});
        vecs.push_back('{16'h0005, 1'b1, 4'b0000, 0, 7'h12, 4'b1110, 1'b1});
        vecs.push_back('{16'h0005, 1'b1, 4'b0000, 1, 7'h40, 4'b1111, 1'b1});
        vecs.push_back('{16'h0005, 1'b1, 4'b0000, 3, 7'h40, 4'b1111, 1'b1});
        vecs.push_back('{16'h0000, 1'b1, 4'b0000, 0, 7'h40, 4'b1110, 1'b1});
        vecs.push_back('{16'h0000, 1'b1, 4'b0000, 2, 7'h40, 4'b1111, 1'b1});
        vecs.push_back('{16'h0005, 1'b0, 4'b0000, 3, 7'h40, 4'b0111, 1'b1});
        vecs.push_back('{16'h0300, 1'b1, 4'b0000, 3, 7'h40, 4'b1111, 1'b1});
        vecs.push_back('{16'h0300, 1'b1, 4'b0000, 2, 7'h30, 4'b1011, 1'b1});
        vecs.push_back('{16'h0300, 1'b1, 4'b0000, 1, 7'h40, 4'b1101, 1'b1});
        vecs.push_back('{16'h89CD, 1'b0, 4'b0101, 0, 7'h21, 4'b1110, 1'b0});
        vecs.push_back('{16'h89CD, 1'b0, 4'b0101, 1, 7'h46, 4'b1101, 1'b1});
        vecs.push_back('{16'h89CD, 1'b0, 4'b0101, 2, 7'h10, 4'b1011, 1'b0});
        vecs.push_back('{16'h89CD, 1'b0, 4'b0101, 3, 7'h00, 4'b0111, 1'b1});
        vecs.push_back('{16'h4567, 1'b0, 4'b1000, 0, 7'h78, 4'b1110, 1'b1});
        vecs.push_back('{16'h4567, 1'b0, 4'b1000, 1, 7'h02, 4'b1101, 1'b1});
        vecs.push_back('{16'h4567, 1'b0, 4'b1000, 2, 7'h12, 4'b1011, 1'b1});
        vecs.push_back('{16'h4567, 1'b0, 4'b1000, 3, 7'h19, 4'b0111, 1'b0});
        vecs.push_back('{16'h0B0E, 1'b1, 4'b0000, 3, 7'h40, 4'b1111, 1'b1});
        vecs.push_back('{16'h0B0E, 1'b1, 4'b0000, 2, 7'h03, 4'b1011, 1'b1});
        vecs.push_back('{16'h0B0E, 1'b1, 4'b0000, 0, 7'h06, 4'b1110, 1'b1});

        foreach (vecs[k]) begin
            do_reset();
            set_inputs(vecs[k].data, vecs[k].lz, vecs[k].dpm);
            tick(32 + 8 * vecs[k].slot + 3);
            check($sformatf("vec%0d_seg", k), 32'(bus.seg), 32'(vecs[k].seg));
            check($sformatf("vec%0d_dig", k), 32'(bus.dig), 32'(vecs[k].dig));
            check($sformatf("vec%0d_dp", k), 32'(bus.dp), 32'(vecs[k].dp));
        end

        // Snapshot holds the old frame until the next frame boundary.
        do_reset();
        set_inputs(16'h1111, 1'b0, 4'h0);
        tick(42);
        bus.data = 16'h2222;
        tick(9);
        check("tear_slot2_old", 32'(bus.seg), 32'h79);
        check("tear_slot2_dig", 32'(bus.dig), 32'hB);
        tick(12);
        check("tear_slot3_old", 32'(bus.seg), 32'h79);
        tick(1);
        check("tear_frame_done", 32'(bus.frameDone), 32'h1);
        check("tear_last_old", 32'(bus.seg), 32'h79);
        tick(3);
        check("tear_new_seg", 32'(bus.seg), 32'h24);
        check("tear_new_dig", 32'(bus.dig), 32'hE);

        // Pause in the last slot at cnt=5, then resume from the held count.
        do_reset();
        set_inputs(16'h12AF, 1'b0, 4'h0);
        tick(29);
        check("pause_pre_dig", 32'(bus.dig), 32'h7);
        bus.enable = 1'b0;
        for (int p = 0; p < 10; p++) begin
            tick(1);
            check($sformatf("pause%0d_dig", p), 32'(bus.dig), 32'hF);
            check($sformatf("pause%0d_fd", p), 32'(bus.frameDone), 32'h0);
        end
        bus.enable = 1'b1;
        tick(1);
        check("resume1_dig", 32'(bus.dig), 32'h7);
        check("resume1_fd", 32'(bus.frameDone), 32'h0);
        tick(1);
        check("resume2_dig", 32'(bus.dig), 32'h7);
        check("resume2_fd", 32'(bus.frameDone), 32'h0);
        tick(1);
        check("resume3_dig", 32'(bus.dig), 32'h7);
        check("resume3_fd", 32'(bus.frameDone), 32'h1);
        tick(1);
        check("resume4_dig", 32'(bus.dig), 32'hF);
        check("resume4_fd", 32'(bus.frameDone), 32'h0);

        // Reset mid-frame while slot 2 is lit, after a real snapshot has been taken.
        do_reset();
        set_inputs(16'h12AF, 1'b0, 4'h0);
        tick(52);
        check("midrst_pre_dig", 32'(bus.dig), 32'hB);
        check("midrst_pre_seg", 32'(bus.seg), 32'h24);
        rst = 1'b1;
        tick(1);
        check("midrst_seg", 32'(bus.seg), 32'h7F);
        check("midrst_dp", 32'(bus.dp), 32'h1);
        check("midrst_dig", 32'(bus.dig), 32'hF);
        check("midrst_fd", 32'(bus.frameDone), 32'h0);
        rst = 1'b0;
        tick(2);
        check("midrst_guard", 32'(bus.dig), 32'hF);
        tick(1);
        check("midrst_restart_dig", 32'(bus.dig), 32'hE);
        check("midrst_restart_seg", 32'(bus.seg), 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
